// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single-beat core requests into APB SETUP/ACCESS transfers,
// with a per-transfer wait-state timeout and a saturating abort counter.
module apb_master_bridge #(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // Core side
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [BUS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [7:0]            err_count,
  // APB side
  output logic [BUS_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [BUS_WIDTH-1:0]  paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  timeout_hit;

  // PREADY has priority: the abort only fires on a stalled cycle.
  assign timeout_hit = (state_q == StAccess) && !M_PREADY && (wait_cnt_q == CntLast);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (M_PREADY || timeout_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    // Select/enable are flopped from the next state so they carry no input-to-output path.
    psel_d      = (state_d != StIdle);
    penable_d   = (state_d == StAccess);

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
        end
      end
      StSetup: begin
        wait_cnt_d = '0;
      end
      StAccess: begin
        if (M_PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : M_PRDATA;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == StIdle) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;
  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PWDATA  = pwdata_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;

endmodule
